pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Pipelined successor to the single-cycle main decoder.
- Decodes the 6-bit opcode in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles.
- Honours a flush from the branch/jump resolver and produces EX-stage forwarding selects for the datapath.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- ALUOP_W, 2: ALUOp field width; the upper bits are zero-extended.
- FWD_EN, 1: 1 generates forwarding selects; 0 ties forwardA_o/forwardB_o to 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  the instruction in IF/ID is valid.
- Op_i  in  6  opcode of the ID instruction.
- Rs_i  in  REG_ADDR_W  rs of the ID instruction.
- Rt_i  in  REG_ADDR_W  rt of the ID instruction.
- Rd_i  in  REG_ADDR_W  rd of the ID instruction.
- flush_i  in  1  kill the ID instruction (taken branch or jump).
- Branch_o  out  1  ID-stage decode, combinational.
- Jump_o  out  1  ID-stage decode, combinational.
- stall_o  out  1  load-use hazard detected this cycle.
- PCWrite_o  out  1  PC enable, equal to ~stall_o.
- IFIDWrite_o  out  1  IF/ID register enable, equal to ~stall_o.
- ex_ALUSrc_o  out  1  EX-stage registered control.
- ex_ALUOp_o  out  ALUOP_W  EX-stage registered control.
- ex_WriteReg_o  out  REG_ADDR_W  EX-stage destination register.
- ex_illegal_o  out  1  unknown opcode reached EX.
- forwardA_o  out  2  EX operand A source select.
- forwardB_o  out  2  EX operand B source select.
- mem_MemRead_o  out  1  MEM-stage registered control.
- mem_MemWrite_o  out  1  MEM-stage registered control.
- mem_WriteReg_o  out  REG_ADDR_W  MEM-stage destination register.
- mem_RegWrite_o  out  1  MEM-stage registered control.
- wb_RegWrite_o  out  1  WB-stage registered control.
- wb_MemtoReg_o  out  1  WB-stage registered control.
- wb_WriteReg_o  out  REG_ADDR_W  WB-stage destination register.

Behaviour:
- Decode table (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp):
  - R-type 000000: 1,0,0,1,0,0,0,0,10
  - addi 001000: 0,1,0,1,0,0,0,0,00
  - lw 100011: 0,1,1,1,1,0,0,0,00
  - sw 101011: 0,1,0,0,0,1,0,0,00
  - beq 000100: 0,0,0,0,0,0,1,0,01
  - j 000010: 0,0,0,0,0,0,0,1,00
- No X values anywhere.
- Unknown opcode: all control 0 and the illegal flag set.
- valid_i=0: all control 0 and the illegal flag 0.
- WriteReg = RegDst ? Rd_i : Rt_i, resolved in ID.
- RegWrite is forced to 0 when WriteReg==0.
- Rt is a source operand only for R-type, sw and beq.
- Hazard condition: valid_i & ex_MemRead & ex_WriteReg!=0 & (ex_WriteReg==Rs_i | (rt_used & ex_WriteReg==Rt_i)).
- stall_o = hazard & ~flush_i. It is combinational.
- Each rising edge, the ID/EX register loads one of:
  - a bubble (all zero) if rst_i, flush_i or stall_o is asserted;
  - otherwise the decoded ID bundle, with Rs/Rt captured internally.
- EX/MEM and MEM/WB advance unconditionally every cycle and never stall.
- Latency: an instruction decoded in cycle n appears in ex_* at n+1, mem_* at n+2 and wb_* at n+3.
- Branch_o and Jump_o are gated by valid_i & ~flush_i.
- Forwarding for operand A (B identical using ex_Rt):
  - 10 when mem_RegWrite & mem_WriteReg==ex_Rs;
  - else 01 when wb_RegWrite & wb_WriteReg==ex_Rs;
  - else 00.
  - MEM has priority over WB.
  - Register 0 never matches, because RegWrite is already forced to 0.
- Reset: every pipeline register clears to 0, so all ex_/mem_/wb_ outputs and forward selects read 0.
- Reset asserted mid-stream: all in-flight instructions are discarded on that edge. stall_o may still evaluate combinationally from current inputs, but the EX contents it depends on are 0 after the edge.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, PC advances and a bubble enters EX.
- A stall lasts exactly one cycle per load, because the bubble clears ex_MemRead.

Test Plan:
- Reset, then each of the 6 opcodes plus 111111 at one per cycle -> ex_ outputs match the table one cycle later, mem_ outputs two cycles later and wb_ outputs three cycles later. 111111 gives ex_illegal_o=1 with all control 0.
- lw $8 followed by add $9,$8,$10 -> stall_o=1 for exactly one cycle; PCWrite_o=IFIDWrite_o=0; a bubble appears in EX. The next cycle the add enters EX with forwardA_o=01, since the lw is then in WB.
- lw $8 followed by sw $8,0($8) under flush_i=1 -> stall_o=0; the ID/EX register loads a bubble; no mem_MemWrite_o three cycles later.
- add $5 ; add $5 ; add $6,$5,$5 -> forwardA_o=forwardB_o=10, selecting the MEM source over the WB source.
- addi $0,$1,4 -> wb_RegWrite_o=0 and no forwarding match on register 0.
- rst_i pulsed while 3 instructions are in flight -> every ex_/mem_/wb_ output is 0 on the next cycle.

Source files
------------

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined main decoder with load-use stall, flush and EX forwarding selects.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [5:0]            Op_i,
  input  logic [REG_ADDR_W-1:0] Rs_i,
  input  logic [REG_ADDR_W-1:0] Rt_i,
  input  logic [REG_ADDR_W-1:0] Rd_i,
  input  logic                  flush_i,
  output logic                  Branch_o,
  output logic                  Jump_o,
  output logic                  stall_o,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  ex_ALUSrc_o,
  output logic [ALUOP_W-1:0]    ex_ALUOp_o,
  output logic [REG_ADDR_W-1:0] ex_WriteReg_o,
  output logic                  ex_illegal_o,
  output logic [1:0]            forwardA_o,
  output logic [1:0]            forwardB_o,
  output logic                  mem_MemRead_o,
  output logic                  mem_MemWrite_o,
  output logic [REG_ADDR_W-1:0] mem_WriteReg_o,
  output logic                  mem_RegWrite_o,
  output logic                  wb_RegWrite_o,
  output logic                  wb_MemtoReg_o,
  output logic [REG_ADDR_W-1:0] wb_WriteReg_o
);
  typedef struct packed {
    logic                  alu_src;
    logic [ALUOP_W-1:0]    alu_op;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  illegal;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } idex_t;
  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
  } exmem_t;
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
  } memwb_t;
  idex_t  id_ctl, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic [9:0] ctl;
  logic illegal, rt_used, hazard;
  // ctl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}
  always_comb begin
    ctl = '0;
    illegal = 1'b0;
    if (valid_i)
      case (Op_i)
        6'b000000: ctl = 10'b1001000010;
        6'b001000: ctl = 10'b0101000000;
        6'b100011: ctl = 10'b0111100000;
        6'b101011: ctl = 10'b0100010000;
        6'b000100: ctl = 10'b0000001001;
        6'b000010: ctl = 10'b0000000100;
        default:   illegal = 1'b1;
      endcase
  end
  always_comb begin
    id_ctl = '0;
    id_ctl.alu_src = ctl[8];
    id_ctl.alu_op = ALUOP_W'(ctl[1:0]);
    id_ctl.write_reg = valid_i ? (ctl[9] ? Rd_i : Rt_i) : '0;
    id_ctl.illegal = illegal;
    id_ctl.mem_read = ctl[5];
    id_ctl.mem_write = ctl[4];
    id_ctl.reg_write = ctl[6] & (id_ctl.write_reg != '0);
    id_ctl.mem_to_reg = ctl[7];
    id_ctl.rs = valid_i ? Rs_i : '0;
    id_ctl.rt = valid_i ? Rt_i : '0;
  end
  assign rt_used = (Op_i == 6'b000000) | (Op_i == 6'b101011) | (Op_i == 6'b000100);
  assign hazard = valid_i & idex_q.mem_read & (idex_q.write_reg != '0) &
                  ((idex_q.write_reg == Rs_i) | (rt_used & (idex_q.write_reg == Rt_i)));
  assign stall_o = hazard & ~flush_i;
  assign PCWrite_o = ~stall_o;
  assign IFIDWrite_o = ~stall_o;
  assign Branch_o = ctl[3] & ~flush_i;
  assign Jump_o = ctl[2] & ~flush_i;
  always_comb begin
    idex_d = (flush_i | stall_o) ? '0 : id_ctl;
    exmem_d = {idex_q.mem_read, idex_q.mem_write, idex_q.reg_write, idex_q.mem_to_reg, idex_q.write_reg};
    memwb_d = {exmem_q.reg_write, exmem_q.mem_to_reg, exmem_q.write_reg};
  end
  always_ff @(posedge clk_i) begin
    idex_q <= rst_i ? '0 : idex_d;
    exmem_q <= rst_i ? '0 : exmem_d;
    memwb_q <= rst_i ? '0 : memwb_d;
  end
  // MEM holds the younger producer, so it outranks WB
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] r);
    return (FWD_EN == 0) ? 2'b00 :
           (exmem_q.reg_write && exmem_q.write_reg == r) ? 2'b10 :
           (memwb_q.reg_write && memwb_q.write_reg == r) ? 2'b01 : 2'b00;
  endfunction
  assign forwardA_o = fwd_sel(idex_q.rs);
  assign forwardB_o = fwd_sel(idex_q.rt);
  assign ex_ALUSrc_o = idex_q.alu_src;
  assign ex_ALUOp_o = idex_q.alu_op;
  assign ex_WriteReg_o = idex_q.write_reg;
  assign ex_illegal_o = idex_q.illegal;
  assign mem_MemRead_o = exmem_q.mem_read;
  assign mem_MemWrite_o = exmem_q.mem_write;
  assign mem_WriteReg_o = exmem_q.write_reg;
  assign mem_RegWrite_o = exmem_q.reg_write;
  assign wb_RegWrite_o = memwb_q.reg_write;
  assign wb_MemtoReg_o = memwb_q.mem_to_reg;
  assign wb_WriteReg_o = memwb_q.write_reg;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed and random stimulus scored against a queued reference model.
module tb_pipe_control_unit;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02, OP_BAD = 6'h3f;
  logic clk_i = 1'b0;
  logic rst_i, valid_i, flush_i;
  logic [5:0] Op_i;
  logic [4:0] Rs_i, Rt_i, Rd_i;
  logic Branch_o, Jump_o, stall_o, PCWrite_o, IFIDWrite_o;
  logic ex_ALUSrc_o, ex_illegal_o;
  logic [1:0] ex_ALUOp_o, forwardA_o, forwardB_o;
  logic [4:0] ex_WriteReg_o, mem_WriteReg_o, wb_WriteReg_o;
  logic mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o, wb_RegWrite_o, wb_MemtoReg_o;
  always #5 clk_i = ~clk_i;
  pipe_control_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i), .Rs_i(Rs_i), .Rt_i(Rt_i),
    .Rd_i(Rd_i), .flush_i(flush_i), .Branch_o(Branch_o), .Jump_o(Jump_o), .stall_o(stall_o),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o),
    .ex_ALUOp_o(ex_ALUOp_o), .ex_WriteReg_o(ex_WriteReg_o), .ex_illegal_o(ex_illegal_o),
    .forwardA_o(forwardA_o), .forwardB_o(forwardB_o), .mem_MemRead_o(mem_MemRead_o),
    .mem_MemWrite_o(mem_MemWrite_o), .mem_WriteReg_o(mem_WriteReg_o),
    .mem_RegWrite_o(mem_RegWrite_o), .wb_RegWrite_o(wb_RegWrite_o),
    .wb_MemtoReg_o(wb_MemtoReg_o), .wb_WriteReg_o(wb_WriteReg_o)
  );
  typedef struct packed {
    logic alu_src;
    logic [1:0] alu_op;
    logic [4:0] wr;
    logic ill, mr, mw, rw, m2r;
    logic [4:0] rs, rt;
  } stage_t;
  typedef struct packed {
    logic stall, br, jp;
    logic [1:0] fa, fb;
    stage_t ex, mem, wb;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  stage_t ex_m, mem_m, wb_m;
  logic last_stall = 1'b0;
  int checks = 0, failures = 0;
  function automatic logic [1:0] fwd(input stage_t m, input stage_t w, input logic [4:0] r);
    if (m.rw && m.wr == r) return 2'b10;
    if (w.rw && w.wr == r) return 2'b01;
    return 2'b00;
  endfunction
  task automatic issue(input logic rst, input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl);
    logic [9:0] c;
    logic known, used, hz;
    stage_t d;
    exp_t e;
    rst_i = rst; valid_i = v; Op_i = op; Rs_i = rs; Rt_i = rt; Rd_i = rd; flush_i = fl;
    known = 1'b1;
    case (op)
      OP_R:    c = 10'b1001000010;
      OP_ADDI: c = 10'b0101000000;
      OP_LW:   c = 10'b0111100000;
      OP_SW:   c = 10'b0100010000;
      OP_BEQ:  c = 10'b0000001001;
      OP_J:    c = 10'b0000000100;
      default: begin c = '0; known = 1'b0; end
    endcase
    if (!v) c = '0;
    d = '0;
    if (v) begin
      d.alu_src = c[8]; d.alu_op = c[1:0]; d.wr = c[9] ? rd : rt; d.ill = !known;
      d.mr = c[5]; d.mw = c[4]; d.rw = c[6] && d.wr != 0; d.m2r = c[7]; d.rs = rs; d.rt = rt;
    end
    used = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    hz = v && ex_m.mr && ex_m.wr != 0 && (ex_m.wr == rs || (used && ex_m.wr == rt));
    e.stall = hz && !fl;
    e.br = c[3] && !fl;
    e.jp = c[2] && !fl;
    e.fa = fwd(mem_m, wb_m, ex_m.rs);
    e.fb = fwd(mem_m, wb_m, ex_m.rt);
    e.ex = ex_m; e.mem = mem_m; e.wb = wb_m;
    sb.push_back(e);
    last_stall = e.stall;
    if (rst) begin
      ex_m = '0; mem_m = '0; wb_m = '0;
    end else begin
      wb_m = mem_m; mem_m = ex_m; ex_m = (fl || e.stall) ? '0 : d;
    end
    @(posedge clk_i); #1;
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask
  initial forever begin
    @(negedge clk_i);
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("stall", {29'd0, stall_o, PCWrite_o, IFIDWrite_o}, {29'd0, mon_e.stall, !mon_e.stall, !mon_e.stall});
      chk("branch_jump", {30'd0, Branch_o, Jump_o}, {30'd0, mon_e.br, mon_e.jp});
      chk("ex", {23'd0, ex_ALUSrc_o, ex_ALUOp_o, ex_WriteReg_o, ex_illegal_o},
          {23'd0, mon_e.ex.alu_src, mon_e.ex.alu_op, mon_e.ex.wr, mon_e.ex.ill});
      chk("forward", {28'd0, forwardA_o, forwardB_o}, {28'd0, mon_e.fa, mon_e.fb});
      chk("mem", {24'd0, mem_MemRead_o, mem_MemWrite_o, mem_WriteReg_o, mem_RegWrite_o},
          {24'd0, mon_e.mem.mr, mon_e.mem.mw, mon_e.mem.wr, mon_e.mem.rw});
      chk("wb", {25'd0, wb_RegWrite_o, wb_MemtoReg_o, wb_WriteReg_o},
          {25'd0, mon_e.wb.rw, mon_e.wb.m2r, mon_e.wb.wr});
    end
  end
  logic [5:0] op_tab [6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  initial begin
    logic r_v, r_fl, r_rst;
    logic [5:0] r_op;
    logic [4:0] r_rs, r_rt, r_rd;
    int k;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; Op_i = '0; Rs_i = '0; Rt_i = '0; Rd_i = '0;
    ex_m = '0; mem_m = '0; wb_m = '0;
    r_v = 1'b0; r_fl = 1'b0; r_rst = 1'b0; r_op = '0; r_rs = '0; r_rt = '0; r_rd = '0;
    repeat (2) @(posedge clk_i);
    #1;
    issue(0, 1, OP_R, 5'd1, 5'd2, 5'd3, 0);
    issue(0, 1, OP_ADDI, 5'd4, 5'd5, 5'd0, 0);
    issue(0, 1, OP_LW, 5'd6, 5'd7, 5'd0, 0);
    issue(0, 1, OP_SW, 5'd1, 5'd2, 5'd0, 0);
    issue(0, 1, OP_BEQ, 5'd3, 5'd4, 5'd0, 0);
    issue(0, 1, OP_J, 5'd0, 5'd0, 5'd0, 0);
    issue(0, 1, OP_BAD, 5'd9, 5'd10, 5'd11, 0);
    nops(3);
    issue(0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
    issue(0, 1, OP_R, 5'd8, 5'd10, 5'd9, 0);
    issue(0, 1, OP_R, 5'd8, 5'd10, 5'd9, 0);
    nops(3);
    issue(0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
    issue(0, 1, OP_SW, 5'd8, 5'd8, 5'd0, 1);
    nops(4);
    issue(0, 1, OP_R, 5'd1, 5'd2, 5'd5, 0);
    issue(0, 1, OP_R, 5'd3, 5'd4, 5'd5, 0);
    issue(0, 1, OP_R, 5'd5, 5'd5, 5'd6, 0);
    nops(3);
    issue(0, 1, OP_ADDI, 5'd1, 5'd0, 5'd0, 0);
    issue(0, 1, OP_R, 5'd0, 5'd0, 5'd7, 0);
    nops(3);
    issue(0, 1, OP_R, 5'd1, 5'd2, 5'd3, 0);
    issue(0, 1, OP_LW, 5'd4, 5'd5, 5'd0, 0);
    issue(0, 1, OP_ADDI, 5'd6, 5'd7, 5'd0, 0);
    issue(1, 1, OP_R, 5'd7, 5'd5, 5'd2, 0);
    nops(2);
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r_v = $urandom_range(0, 9) != 0;
        k = $urandom_range(0, 7);
        r_op = (k < 6) ? op_tab[k] : 6'($urandom_range(0, 63));
        r_rs = 5'($urandom_range(0, 7));
        r_rt = 5'($urandom_range(0, 7));
        r_rd = 5'($urandom_range(0, 7));
        r_fl = $urandom_range(0, 9) == 0;
        r_rst = $urandom_range(0, 49) == 0;
      end else begin
        r_fl = 1'b0;
        r_rst = 1'b0;
      end
      issue(r_rst, r_v, r_op, r_rs, r_rt, r_rd, r_fl);
    end
    repeat (2) @(posedge clk_i);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
